vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 94 +++++++++
 tb/tb_vga_sync_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate enable, horizontal/vertical counters,
// registered active-low syncs, active-region flag and end-of-frame strobe.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int HD      = 640,
  parameter int HF      = 16,
  parameter int HB      = 48,
  parameter int HR      = 96,
  parameter int VD      = 480,
  parameter int VF      = 10,
  parameter int VB      = 33,
  parameter int VR      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       end_of_frame
);

  localparam logic [9:0] H_MAX    = 10'(HD + HF + HB + HR - 1);
  localparam logic [9:0] V_MAX    = 10'(VD + VF + VB + VR - 1);
  localparam logic [9:0] H_ACTIVE = 10'(HD);
  localparam logic [9:0] V_ACTIVE = 10'(VD);
  localparam logic [9:0] HS_START = 10'(HD + HF);
  localparam logic [9:0] HS_END   = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VS_START = 10'(VD + VF);
  localparam logic [9:0] VS_END   = 10'(VD + VF + VR - 1);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;

  // A divide-by-one needs no counter: every clock is a pixel clock.
  generate
    if (CLK_DIV == 1) begin : g_no_div
      assign p_tick = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
      logic [DW-1:0] div_cnt;

      // NOTE: sequential state is written with non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                        div_cnt <= div_cnt + DW'(1);
      end

      assign p_tick = (div_cnt == DIV_LAST);
    end
  endgenerate

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (p_tick) begin
      if (h_cnt == H_MAX) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  // Syncs decode the next-state counters so they switch on the same edge as
  // pixel_x/pixel_y and come straight from flops (glitch-free).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      hsync <= !((h_nxt >= HS_START) && (h_nxt <= HS_END));
      vsync <= !((v_nxt >= VS_START) && (v_nxt <= VS_END));
    end
  end

  assign video_on     = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
  assign end_of_frame = p_tick && (h_cnt == H_MAX) && (v_cnt == V_MAX);
  assign pixel_x      = h_cnt;
  assign pixel_y      = v_cnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing with a divide-by-4 pixel clock,
// plus a tiny divide-by-1 configuration small enough to run whole frames.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_s_n;
  logic       d_hs, d_vs, d_vo, d_pt, d_eof;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_vo, s_pt, s_eof;
  logic [9:0] s_x, s_y;

  vga_sync_gen dut (
    .clk(clk), .rst_n(rst_n), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
    .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y), .end_of_frame(d_eof)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .HD(8), .HF(2), .HB(2), .HR(2), .VD(4), .VF(1), .VB(1), .VR(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_s_n), .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
    .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y), .end_of_frame(s_eof)
  );

  typedef struct {
    int         n;      // clk edges since reset release
    logic [9:0] x, y;
    logic       hs, vs, vo, pt, eof;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int n, int x, int y, int hs, int vs, int vo, int pt, int eof);
    vec_t v;
    v.n = n; v.x = 10'(x); v.y = 10'(y);
    v.hs = 1'(hs); v.vs = 1'(vs); v.vo = 1'(vo); v.pt = 1'(pt); v.eof = 1'(eof);
    return v;
  endfunction

  function automatic logic [31:0] exp_of(vec_t v);
    return 32'({v.x, v.y, v.hs, v.vs, v.vo, v.pt, v.eof});
  endfunction

  function automatic logic [31:0] d_act();
    return 32'({d_x, d_y, d_hs, d_vs, d_vo, d_pt, d_eof});
  endfunction

  function automatic logic [31:0] s_act();
    return 32'({s_x, s_y, s_hs, s_vs, s_vo, s_pt, s_eof});
  endfunction

  vec_t vecs[14];
  int   ecount;
  int   eof_cnt, eof_first, eof_second, vs_low, hs_low, pt_low;

  initial begin
    vecs[0]  = mk(0,    0,   0, 1, 1, 1, 0, 0);
    vecs[1]  = mk(2,    0,   0, 1, 1, 1, 0, 0);
    vecs[2]  = mk(3,    0,   0, 1, 1, 1, 1, 0);
    vecs[3]  = mk(4,    1,   0, 1, 1, 1, 0, 0);
    vecs[4]  = mk(7,    1,   0, 1, 1, 1, 1, 0);
    vecs[5]  = mk(2559, 639, 0, 1, 1, 1, 1, 0);
    vecs[6]  = mk(2560, 640, 0, 1, 1, 0, 0, 0);
    vecs[7]  = mk(2623, 655, 0, 1, 1, 0, 1, 0);
    vecs[8]  = mk(2624, 656, 0, 0, 1, 0, 0, 0);
    vecs[9]  = mk(3007, 751, 0, 0, 1, 0, 1, 0);
    vecs[10] = mk(3008, 752, 0, 1, 1, 0, 0, 0);
    vecs[11] = mk(3199, 799, 0, 1, 1, 0, 1, 0);
    vecs[12] = mk(3200, 0,   1, 1, 1, 1, 0, 0);
    vecs[13] = mk(3203, 0,   1, 1, 1, 1, 1, 0);

    rst_n   = 1'b0;
    rst_s_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_default", d_act(), exp_of(mk(0, 0, 0, 1, 1, 1, 0, 0)));
    check("reset_small",   s_act(), exp_of(mk(0, 0, 0, 1, 1, 1, 1, 0)));

    // Default configuration: time-indexed table over the first two lines.
    @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
    #1;
    for (int i = 0; i < 14; i++) begin
      while (ecount < vecs[i].n) begin
        @(posedge clk);
        ecount++;
        #1;
      end
      check($sformatf("vec_n%0d", vecs[i].n), d_act(), exp_of(vecs[i]));
    end

    // Mid-frame, mid-divide asynchronous reset at (700,1) inside hsync.
    while (ecount < 6001) begin
      @(posedge clk);
      ecount++;
      #1;
    end
    check("pre_reset_700_1", d_act(), exp_of(mk(6001, 700, 1, 0, 1, 0, 0, 0)));
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", d_act(), exp_of(mk(0, 0, 0, 1, 1, 1, 0, 0)));
    repeat (2) @(posedge clk);
    #1;
    check("held_reset", d_act(), exp_of(mk(0, 0, 0, 1, 1, 1, 0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("restart_tick", d_act(), exp_of(mk(3, 0, 0, 1, 1, 1, 1, 0)));
    @(posedge clk);
    #1;
    check("restart_x1", d_act(), exp_of(mk(4, 1, 0, 1, 1, 1, 0, 0)));

    // Small configuration: two whole frames (98 clk each), divide-by-1.
    eof_cnt = 0; eof_first = -1; eof_second = -1;
    vs_low = 0; hs_low = 0; pt_low = 0;
    @(negedge clk);
    rst_s_n = 1'b1;
    #1;
    check("small_start", s_act(), exp_of(mk(0, 0, 0, 1, 1, 1, 1, 0)));
    for (int n = 1; n <= 196; n++) begin
      @(posedge clk);
      #1;
      if (s_eof) begin
        eof_cnt++;
        if (eof_cnt == 1) eof_first = n;
        if (eof_cnt == 2) eof_second = n;
      end
      if (!s_vs) vs_low++;
      if (!s_hs) hs_low++;
      if (!s_pt) pt_low++;
      if (n == 10) check("small_hs_fall", s_act(), exp_of(mk(10, 10, 0, 0, 1, 0, 1, 0)));
      if (n == 12) check("small_hs_rise", s_act(), exp_of(mk(12, 12, 0, 1, 1, 0, 1, 0)));
      if (n == 69) check("small_vs_before", s_act(), exp_of(mk(69, 13, 4, 1, 1, 0, 1, 0)));
      if (n == 70) check("small_vs_fall", s_act(), exp_of(mk(70, 0, 5, 1, 0, 0, 1, 0)));
      if (n == 84) check("small_vs_rise", s_act(), exp_of(mk(84, 0, 6, 1, 1, 0, 1, 0)));
      if (n == 97) check("small_eof", s_act(), exp_of(mk(97, 13, 6, 1, 1, 0, 1, 1)));
      if (n == 98) check("small_wrap", s_act(), exp_of(mk(98, 0, 0, 1, 1, 1, 1, 0)));
    end
    check("small_eof_count",  32'(eof_cnt),    32'd2);
    check("small_eof_first",  32'(eof_first),  32'd97);
    check("small_eof_period", 32'(eof_second), 32'd195);
    check("small_vs_low_clks", 32'(vs_low),    32'd28);
    check("small_hs_low_clks", 32'(hs_low),    32'd28);
    check("small_ptick_low",   32'(pt_low),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
